// File: rtl/oai211_bist_pkg.sv
// rtl/oai211_bist_pkg.sv - shared types and constants for the oai211 cell BIST controller
package oai211_bist_pkg;

    localparam int VEC_W = 4;
    localparam int CNT_W = 5;

    // ZN = !((A1|A2)&B&C): low only for vectors 13, 14, 15
    localparam logic [15:0] OAI211_TT = 16'h1FFF;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FINISH
    } bist_state_e;

endpackage

// File: rtl/bist_settle_timer.sv
// rtl/bist_settle_timer.sv - 4-bit load/decrement settle counter with expire flag
module bist_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       expire
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiring at 1 makes the dwell equal to the loaded value
    assign expire = (cnt_q == 4'd1);

endmodule

// File: rtl/oai211_cell_bist_ctrl.sv
// rtl/oai211_cell_bist_ctrl.sv - exhaustive 16-vector BIST sequencer for a 4-input cell
module oai211_cell_bist_ctrl
    import oai211_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXP_TT        = OAI211_TT
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    input  logic             ZN_OBS,
    output logic             A1,
    output logic             A2,
    output logic             B,
    output logic             C,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             FAIL_VLD,
    output logic [VEC_W-1:0] FAIL_VEC
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    bist_state_e      state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [VEC_W-1:0] stim_q, stim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             fail_vld_q, fail_vld_d;
    logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
    logic             settle_expire;
    logic             run_abort;
    logic             mismatch;

    assign run_abort = ABORT && (state_q != IDLE);
    assign mismatch  = (ZN_OBS != EXP_TT[vec_q]);

    bist_settle_timer u_settle_timer (
        .clk      (CLK),
        .rst_n    (RN),
        .load     (state_q == APPLY),
        .load_val (SETTLE_LD),
        .dec      (state_q == SETTLE),
        .expire   (settle_expire)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START && !ABORT) state_d = APPLY;
            APPLY:   state_d = SETTLE;
            SETTLE:  if (settle_expire) state_d = SAMPLE;
            SAMPLE:  state_d = (vec_q == 4'hF) ? FINISH : APPLY;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (run_abort) state_d = IDLE;
    end

    always_comb begin
        vec_d      = vec_q;
        stim_d     = stim_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
        case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    vec_d      = '0;
                    err_cnt_d  = '0;
                    fail_vld_d = 1'b0;
                    fail_vec_d = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            APPLY: stim_d = vec_q;
            SAMPLE: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + 5'd1;
                    if (!fail_vld_q) begin
                        fail_vec_d = vec_q;
                        fail_vld_d = 1'b1;
                    end
                end
                if (vec_q != 4'hF) vec_d = vec_q + 4'd1;
            end
            FINISH: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_cnt_q == '0);
                stim_d = '0;
            end
            default: ;
        endcase
        // An abandoned run never reports completion
        if (run_abort) begin
            busy_d = 1'b0;
            stim_d = '0;
            done_d = done_q;
            pass_d = pass_q;
        end
    end

    assign {C, B, A2, A1} = stim_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_cnt_q;
    assign FAIL_VLD = fail_vld_q;
    assign FAIL_VEC = fail_vec_q;

endmodule

// File: tb/tb_oai211_cell_bist_ctrl.sv
// tb/tb_oai211_cell_bist_ctrl.sv - self-checking bench for oai211_cell_bist_ctrl
module tb_oai211_cell_bist_ctrl;

    logic       CLK = 1'b0;
    logic       rn;
    logic       start    [3];
    logic       abort    [3];
    logic       zn       [3];
    logic       a1       [3];
    logic       a2       [3];
    logic       b        [3];
    logic       c        [3];
    logic       busy     [3];
    logic       done     [3];
    logic       pass     [3];
    logic [4:0] err_cnt  [3];
    logic       fail_vld [3];
    logic [3:0] fail_vec [3];
    int         mode     [3];
    logic [15:0] mask    [3];

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    function automatic int sc_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 15;
    endfunction

    function automatic logic good(input logic [3:0] v);
        return !((v[0] | v[1]) & v[2] & v[3]);
    endfunction

    // mode 0: healthy cell with per-vector flips from mask; 1: stuck-at-1; 2: stuck-at-0
    function automatic logic zn_fn(input int m, input logic [15:0] mk, input logic [3:0] v);
        if (m == 1) return 1'b1;
        if (m == 2) return 1'b0;
        return good(v) ^ mk[v];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        oai211_cell_bist_ctrl #(.SETTLE_CYCLES(S)) u_dut (
            .CLK      (CLK),
            .RN       (rn),
            .START    (start[g]),
            .ABORT    (abort[g]),
            .ZN_OBS   (zn[g]),
            .A1       (a1[g]),
            .A2       (a2[g]),
            .B        (b[g]),
            .C        (c[g]),
            .BUSY     (busy[g]),
            .DONE     (done[g]),
            .PASS     (pass[g]),
            .ERR_CNT  (err_cnt[g]),
            .FAIL_VLD (fail_vld[g]),
            .FAIL_VEC (fail_vec[g])
        );
        assign zn[g] = zn_fn(mode[g], mask[g], {c[g], b[g], a2[g], a1[g]});
    end

    function automatic int stim(input int i);
        return int'({c[i], b[i], a2[i], a1[i]});
    endfunction

    function automatic int all_out(input int i);
        return int'({a1[i], a2[i], b[i], c[i], busy[i], done[i], pass[i],
                     fail_vld[i], err_cnt[i], fail_vec[i]});
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int m, input logic [15:0] mk, input int upto,
                                  output int ec, output int fv);
        ec = 0;
        fv = 0;
        for (int v = 0; v < upto; v++) begin
            if (zn_fn(m, mk, 4'(v)) != good(4'(v))) begin
                if (ec == 0) fv = v;
                ec++;
            end
        end
    endfunction

    task automatic launch(input int i);
        @(negedge CLK);
        start[i] = 1'b1;
        @(posedge CLK);
        #1;
        start[i] = 1'b0;
    endtask

    task automatic do_run(input int i, input int m, input logic [15:0] mk, input int poke);
        int s, total, n, stim_bad, busy_bad, exp_err, exp_first;
        s     = sc_of(i);
        total = 16 * (s + 2);
        mode[i] = m;
        mask[i] = mk;
        model(m, mk, 16, exp_err, exp_first);
        launch(i);
        check("busy_after_start", int'(busy[i]), 1);
        n = 0;
        stim_bad = 0;
        busy_bad = 0;
        while (n < total + 5) begin
            @(posedge CLK);
            #1;
            n++;
            start[i] = (n == poke);
            if (done[i] === 1'b1) break;
            if (busy[i] !== 1'b1) busy_bad++;
            if (stim(i) != (n - 1) / (s + 2)) stim_bad++;
        end
        start[i] = 1'b0;
        check("run_length_edges", n, total + 1);
        check("busy_during_run", busy_bad, 0);
        check("stim_dwell_sequence", stim_bad, 0);
        check("busy_after_done", int'(busy[i]), 0);
        check("done", int'(done[i]), 1);
        check("pass", int'(pass[i]), int'(exp_err == 0));
        check("err_cnt", int'(err_cnt[i]), exp_err);
        check("fail_vld", int'(fail_vld[i]), int'(exp_err != 0));
        check("fail_vec", int'(fail_vec[i]), exp_first);
        check("stim_idle", stim(i), 0);
    endtask

    initial begin
        int e, f, held_err;
        rn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            mode[i]  = 0;
            mask[i]  = '0;
        end
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) check("reset_outputs", all_out(i), 0);
        @(negedge CLK);
        rn = 1'b1;

        do_run(0, 0, 16'h0000, 0);
        do_run(0, 1, 16'h0000, 0);
        do_run(0, 2, 16'h0000, 0);
        for (int k = 0; k < 3; k++) do_run(0, 0, 16'($urandom), (k == 0) ? 10 : 0);

        // START with ABORT in IDLE: no run, results held
        held_err = int'(err_cnt[0]);
        @(negedge CLK);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge CLK);
        #1;
        start[0] = 1'b0;
        abort[0] = 1'b0;
        @(posedge CLK);
        #1;
        check("start_abort_busy", int'(busy[0]), 0);
        check("start_abort_done_held", int'(done[0]), 1);
        check("start_abort_err_held", int'(err_cnt[0]), held_err);
        check("start_abort_stim", stim(0), 0);

        do_run(1, 0, 16'($urandom), 0);
        do_run(2, 0, 16'($urandom), 0);

        // Abort once vector 6 is on the stimulus pins
        mode[0] = 1;
        mask[0] = '0;
        launch(0);
        for (int k = 0; k < 25; k++) begin
            @(posedge CLK);
            #1;
        end
        check("abort_pre_stim", stim(0), 6);
        abort[0] = 1'b1;
        @(posedge CLK);
        #1;
        abort[0] = 1'b0;
        check("abort_busy", int'(busy[0]), 0);
        check("abort_done", int'(done[0]), 0);
        check("abort_stim", stim(0), 0);
        check("abort_err_cnt", int'(err_cnt[0]), 0);
        repeat (3) @(posedge CLK);
        #1;
        check("abort_stays_idle", int'(busy[0]) + stim(0), 0);
        do_run(0, 1, 16'h0000, 0);

        // Asynchronous reset while settling vector 9 of a stuck-at-0 run
        mode[0] = 2;
        launch(0);
        for (int k = 0; k < 37; k++) begin
            @(posedge CLK);
            #1;
        end
        model(2, 16'h0000, 9, e, f);
        check("prereset_stim", stim(0), 9);
        check("prereset_err_cnt", int'(err_cnt[0]), e);
        check("prereset_fail_vec", int'(fail_vec[0]), f);
        #1;
        rn = 1'b0;
        #1;
        check("async_reset_outputs", all_out(0), 0);
        @(negedge CLK);
        rn = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("post_reset_idle", all_out(0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
